// File: rtl/spi_master_ctrl.sv
// SPI master controller: full-duplex DATA_W-bit transfers, CPOL/CPHA modes 0-3,
// programmable SCK half-period (ClkDiv+1 Clk cycles), NUM_CS one-hot chip selects.
// Start-to-Done latency: if Start is high in cycle N, Done is high in cycle
// N + 1 + (2*DATA_W+2)*(ClkDiv+1). Busy is high from cycle N+1 through the Done
// cycle, so a new Start may be issued in the first cycle Busy reads 0.
module spi_master_ctrl #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
) (
    input  logic                                          Clk,
    input  logic                                          Rst_n,
    input  logic                                          Start,
    input  logic                                          CPol,
    input  logic                                          CPha,
    input  logic                                          LsbFirst,
    input  logic [DIV_W-1:0]                              ClkDiv,
    input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] CsSel,
    input  logic [DATA_W-1:0]                             TxData,
    output logic [DATA_W-1:0]                             RxData,
    output logic                                          Busy,
    output logic                                          Done,
    output logic                                          SCK,
    output logic                                          MOSI,
    input  logic                                          MISO,
    output logic [NUM_CS-1:0]                             CS_n
);

    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_XFER  = 3'd2,
        S_TRAIL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DIV_W-1:0]    r_div;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [CS_W-1:0]     r_cs;
    logic                r_cpha;
    logic                r_lsb;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   r_rx_out;
    logic                r_mosi;
    logic                r_sck;
    logic [EDGE_W-1:0]   r_edge;

    logic w_accept;
    logic w_active;
    logic w_tick;
    logic w_odd;
    logic w_sample;
    logic w_shift;

    // r_edge holds the number of edges already produced, so the edge about to
    // happen is r_edge+1; it is odd when r_edge is even.
    assign w_accept = (r_state == S_IDLE) && Start;
    assign w_active = (r_state == S_LEAD) || (r_state == S_XFER) || (r_state == S_TRAIL);
    assign w_tick   = w_active && (r_div_cnt == r_div);
    assign w_odd    = ~r_edge[0];
    assign w_sample = r_cpha ? ~w_odd : w_odd;
    // The first bit is already on MOSI from the accept cycle, so CPha=1 skips
    // the shift on edge 1; CPha=0 skips the shift on the final edge.
    assign w_shift  = r_cpha ? (w_odd && (r_edge != '0)) : (~w_odd && (r_edge != LAST_EDGE));

    // SCK idles at the live CPol input; once a transfer starts the registered copy drives it.
    assign SCK    = (r_state == S_IDLE) ? CPol : r_sck;
    assign MOSI   = r_mosi;
    assign RxData = r_rx_out;

    // State register; reset aborts any transfer immediately.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: each non-idle phase advances on a divider tick.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_next = S_LEAD;
            S_LEAD:  if (w_tick) w_next = S_XFER;
            S_XFER:  if (w_tick && (r_edge == LAST_EDGE)) w_next = S_TRAIL;
            S_TRAIL: if (w_tick) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake and chip-select outputs decoded from the state.
    always_comb begin
        Busy = (r_state != S_IDLE);
        Done = (r_state == S_DONE);
        CS_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (w_active && (CS_W'(i) == r_cs)) CS_n[i] = 1'b0;
        end
    end

    // Config capture, SCK divider, edge counting and the TX/RX shift registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_div     <= '0;
            r_div_cnt <= '0;
            r_cs      <= '0;
            r_cpha    <= 1'b0;
            r_lsb     <= 1'b0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_out  <= '0;
            r_mosi    <= 1'b0;
            r_sck     <= 1'b0;
            r_edge    <= '0;
        end else if (w_accept) begin
            r_div     <= ClkDiv;
            r_div_cnt <= '0;
            r_cs      <= CsSel;
            r_cpha    <= CPha;
            r_lsb     <= LsbFirst;
            r_tx      <= TxData;
            r_rx      <= '0;
            r_mosi    <= LsbFirst ? TxData[0] : TxData[DATA_W-1];
            r_sck     <= CPol;
            r_edge    <= '0;
        end else if (w_active) begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if ((r_state == S_XFER) && w_tick) begin
                r_sck  <= ~r_sck;
                r_edge <= r_edge + 1'b1;
                if (w_sample) begin
                    r_rx <= r_lsb ? {MISO, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], MISO};
                end
                if (w_shift) begin
                    r_tx   <= r_lsb ? (r_tx >> 1) : (r_tx << 1);
                    r_mosi <= r_lsb ? r_tx[1] : r_tx[DATA_W-2];
                end
            end
            if ((r_state == S_TRAIL) && w_tick) r_rx_out <= r_rx;
        end else if (r_state == S_DONE) begin
            r_mosi <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a behavioural SPI slave counts SCK edges, captures
// MOSI and drives MISO by bit index; a scoreboard queue holds the expected
// outcome of each accepted transfer and a monitor checks it when Done pulses.
module tb_spi_master_ctrl;

    localparam int DW  = 8;
    localparam int NCS = 5;
    localparam int DVW = 8;

    logic           Clk = 1'b0;
    logic           Rst_n;
    logic           Start;
    logic           CPol, CPha, LsbFirst;
    logic [DVW-1:0] ClkDiv;
    logic [2:0]     CsSel;
    logic [DW-1:0]  TxData;
    logic [DW-1:0]  RxData;
    logic           Busy, Done, SCK, MOSI, MISO;
    logic [NCS-1:0] CS_n;

    spi_master_ctrl #(.DATA_W(DW), .NUM_CS(NCS), .DIV_W(DVW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .CPol(CPol), .CPha(CPha),
        .LsbFirst(LsbFirst), .ClkDiv(ClkDiv), .CsSel(CsSel), .TxData(TxData),
        .RxData(RxData), .Busy(Busy), .Done(Done), .SCK(SCK), .MOSI(MOSI),
        .MISO(MISO), .CS_n(CS_n)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge Clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [DW-1:0]  rx;
        logic [DW-1:0]  tx;
        int             lat;
        int             t0;
        logic [NCS-1:0] csn;
    } exp_t;

    exp_t sb[$];

    // Behavioural slave state
    bit             xfer_on = 1'b0;
    bit             s_cpha, s_lsb, loopback;
    int             edges, samp_idx;
    logic [DW-1:0]  s_word, mosi_word;
    logic [NCS-1:0] cs_seen;
    bit             cs_bad;
    logic           miso_drv = 1'b0;

    assign MISO = loopback ? MOSI : miso_drv;

    always @(SCK) begin
        if (xfer_on) begin
            bit is_samp;
            edges++;
            is_samp = s_cpha ? (edges % 2 == 0) : (edges % 2 == 1);
            if (is_samp) begin
                if (samp_idx < DW) begin
                    mosi_word[s_lsb ? samp_idx : DW - 1 - samp_idx] = MOSI;
                    if (samp_idx == 0) cs_seen = CS_n;
                    else if (CS_n !== cs_seen) cs_bad = 1'b1;
                end
                samp_idx++;
                if (samp_idx < DW) miso_drv = s_word[s_lsb ? samp_idx : DW - 1 - samp_idx];
            end
        end
    end

    // Monitor: pop and compare on each Done; also check Busy drops the next cycle.
    bit busy_next = 1'b0;
    always @(negedge Clk) begin
        if (busy_next) begin
            chk("busy_after_done", 32'(Busy), 32'd0);
            busy_next = 1'b0;
        end
        if (Rst_n && Done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done RxData=%0h with no transfer pending at %0t", RxData, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rxdata", 32'(RxData), 32'(e.rx));
                chk("mosi_word", 32'(mosi_word), 32'(e.tx));
                chk("latency", 32'(cyc - e.t0), 32'(e.lat));
                chk("sck_edges", 32'(edges), 32'(2 * DW));
                chk("cs_n_during", 32'(cs_seen), 32'(e.csn));
                chk("cs_n_stable", 32'(cs_bad), 32'd0);
                chk("cs_n_done", 32'(CS_n), 32'h1f);
                busy_next = 1'b1;
            end
        end
    end

    task automatic issue(input bit cpol, input bit cpha, input bit lsb, input int div,
                         input int cs, input logic [DW-1:0] tx, input logic [DW-1:0] sw,
                         input bit loop);
        exp_t e;
        logic [NCS-1:0] c;
        xfer_on  = 1'b0;
        CPol     = cpol;
        CPha     = cpha;
        LsbFirst = lsb;
        ClkDiv   = div[DVW-1:0];
        CsSel    = cs[2:0];
        TxData   = tx;
        s_cpha   = cpha;
        s_lsb    = lsb;
        loopback = loop;
        s_word   = sw;
        edges    = 0;
        samp_idx = 0;
        mosi_word = '0;
        cs_bad   = 1'b0;
        cs_seen  = '1;
        miso_drv = lsb ? sw[0] : sw[DW-1];
        c = '1;
        if (cs < NCS) c[cs] = 1'b0;
        e.rx  = loop ? tx : sw;
        e.tx  = tx;
        e.lat = 1 + (2 * DW + 2) * (div + 1);
        e.t0  = cyc;
        e.csn = c;
        sb.push_back(e);
        Start = 1'b1;
        #1 chk("idle_sck", 32'(SCK), 32'(cpol));
        @(posedge Clk);
        xfer_on = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("lead_busy", 32'(Busy), 32'd1);
        chk("lead_mosi", 32'(MOSI), 32'(lsb ? tx[0] : tx[DW-1]));
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge Clk);
        while (Busy && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        chk("idle_timeout", 32'(Busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0; Start = 1'b0; CPol = 1'b0; CPha = 1'b0; LsbFirst = 1'b0;
        ClkDiv = '0; CsSel = '0; TxData = '0; loopback = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_cs_n", 32'(CS_n), 32'h1f);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_rxdata", 32'(RxData), 32'd0);
        chk("rst_mosi", 32'(MOSI), 32'd0);
        chk("rst_sck_lo", 32'(SCK), 32'd0);
        CPol = 1'b1;
        #1 chk("rst_sck_hi", 32'(SCK), 32'd1);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Mode 0, loopback, CS 2
        issue(0, 0, 0, 0, 2, 8'hA5, 8'h00, 1);
        wait_idle();
        // Mode 3, divider 3, slave returns 0x3C
        issue(1, 1, 0, 3, 1, 8'h96, 8'h3C, 0);
        wait_idle();
        // LSB first, mode 1
        issue(0, 1, 1, 0, 0, 8'h01, 8'h80, 0);
        wait_idle();

        // Start while busy must be ignored
        issue(0, 0, 0, 2, 3, 8'h5A, 8'hE7, 0);
        repeat (10) @(negedge Clk);
        Start = 1'b1; TxData = 8'hFF; CsSel = 3'd0; LsbFirst = 1'b1; ClkDiv = 8'd0; CPha = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_idle();
        // Back-to-back on the first Busy-low cycle
        issue(1, 0, 0, 1, 4, 8'hC3, 8'h18, 0);
        wait_idle();

        // Chip select out of range
        issue(0, 0, 0, 1, 5, 8'h33, 8'hCC, 0);
        wait_idle();

        // Reset mid-XFER while SCK is away from its idle level
        issue(1, 0, 0, 1, 1, 8'h96, 8'h69, 0);
        repeat (8) @(negedge Clk);
        xfer_on = 1'b0;
        sb.delete(sb.size() - 1);
        #2 Rst_n = 1'b0;
        #1;
        chk("mid_rst_cs_n", 32'(CS_n), 32'h1f);
        chk("mid_rst_sck", 32'(SCK), 32'(CPol));
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_done", 32'(Done), 32'd0);
        chk("mid_rst_rxdata", 32'(RxData), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);
        issue(0, 1, 0, 0, 0, 8'h7E, 8'hB1, 0);
        wait_idle();

        // Randomised transfers
        for (int k = 0; k < 20; k++) begin
            issue(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  int'($urandom_range(3)), int'($urandom_range(7)),
                  8'($urandom), 8'($urandom), 1'($urandom_range(1)));
            wait_idle();
        end

        repeat (4) @(negedge Clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
